// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - RISC-V M stage: data RAM access and M->W pipeline register
module memory_stage #(
   parameter int DEPTH = 1024,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        RegWriteM,
   input  logic        ResultSrcM,
   input  logic        MemWriteM,
   input  logic [31:0] ALUResultM,
   input  logic [31:0] WriteDataM,
   input  logic [31:0] PCPlus4M,
   input  logic [4:0]  RDM,
   output logic        RegWriteW,
   output logic        ResultSrcW,
   output logic [31:0] ReadDataW,
   output logic [31:0] ALUResultW,
   output logic [31:0] PCPlus4W,
   output logic [4:0]  RDW,
   output logic [31:0] ResultW
);

   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] idx;
   logic [31:0]   rdata;
   logic          unused_addr_bits;

   // Byte offset and bits above the RAM size are dropped, so addresses wrap.
   assign idx              = ALUResultM[AW+1:2];
   assign rdata            = mem[idx];
   assign unused_addr_bits = ^{ALUResultM[31:AW+2], ALUResultM[1:0]};

   always_ff @(posedge clk) begin
      if (rst && MemWriteM) begin
         mem[idx] <= WriteDataM;
      end
   end

   logic        reg_write_d,  reg_write_q;
   logic        result_src_d, result_src_q;
   logic [31:0] read_data_d,  read_data_q;
   logic [31:0] alu_result_d, alu_result_q;
   logic [31:0] pc_plus4_d,   pc_plus4_q;
   logic [4:0]  rd_d,         rd_q;

   always_comb begin
      reg_write_d  = RegWriteM;
      result_src_d = ResultSrcM;
      read_data_d  = rdata;
      alu_result_d = ALUResultM;
      pc_plus4_d   = PCPlus4M;
      rd_d         = RDM;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         reg_write_q  <= 1'b0;
         result_src_q <= 1'b0;
         read_data_q  <= 32'h0;
         alu_result_q <= 32'h0;
         pc_plus4_q   <= 32'h0;
         rd_q         <= 5'h0;
      end else begin
         reg_write_q  <= reg_write_d;
         result_src_q <= result_src_d;
         read_data_q  <= read_data_d;
         alu_result_q <= alu_result_d;
         pc_plus4_q   <= pc_plus4_d;
         rd_q         <= rd_d;
      end
   end

   assign RegWriteW  = reg_write_q;
   assign ResultSrcW = result_src_q;
   assign ReadDataW  = read_data_q;
   assign ALUResultW = alu_result_q;
   assign PCPlus4W   = pc_plus4_q;
   assign RDW        = rd_q;
   assign ResultW    = result_src_q ? read_data_q : alu_result_q;

endmodule
